flag_cond_sequencer: RTL and testbench

//  Consumer side of the C/Z flags register: two-phase fetch/execute sequencer for the processor.

---
 rtl/flag_cond_sequencer.sv | 127 ++++++++++++
 tb/tb_flag_cond_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_sequencer.sv
// Two-phase fetch/execute sequencer: latches instructions, evaluates jump conditions
// against the stored C/Z flags, and keeps saturating branch/taken debug counters.
module flag_cond_sequencer #(
  parameter int          INSTR_W      = 8,
  parameter int          CNT_W        = 8,
  parameter logic [15:0] FLAG_WR_MASK = 16'hF0FC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt_req,
  input  logic [INSTR_W-1:0] instr,
  input  logic               c_flag,
  input  logic               z_flag,
  input  logic               cnt_clr,
  output logic               ir_en,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [INSTR_W-5:0] jump_addr,
  output logic               flags_en,
  output logic               exec_phase,
  output logic [CNT_W-1:0]   branch_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [3:0] OP_JC  = 4'h0;
  localparam logic [3:0] OP_JNC = 4'h1;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JNZ = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;

  state_t               r_state;
  state_t               w_state_next;
  logic [INSTR_W-1:0]   r_ir;
  logic [CNT_W-1:0]     r_branch_cnt;
  logic [CNT_W-1:0]     r_taken_cnt;
  logic [3:0]           w_opcode;
  logic                 w_is_jump;
  logic                 w_cond;

  assign w_opcode = r_ir[INSTR_W-1 -: 4];

  always_comb begin
    w_is_jump = 1'b0;
    w_cond    = 1'b0;
    case (w_opcode)
      OP_JC:   begin w_is_jump = 1'b1; w_cond = c_flag;  end
      OP_JNC:  begin w_is_jump = 1'b1; w_cond = !c_flag; end
      OP_JZ:   begin w_is_jump = 1'b1; w_cond = z_flag;  end
      OP_JNZ:  begin w_is_jump = 1'b1; w_cond = !z_flag; end
      OP_JMP:  begin w_is_jump = 1'b1; w_cond = 1'b1;    end
      default: begin w_is_jump = 1'b0; w_cond = 1'b0;    end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Strobes decode purely from state and IR so an async reset drops them at once.
  always_comb begin
    w_state_next = r_state;
    ir_en        = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    flags_en     = 1'b0;
    exec_phase   = 1'b0;
    case (r_state)
      ST_HALT: begin
        w_state_next = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_FETCH: begin
        ir_en        = 1'b1;
        pc_inc       = 1'b1;
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        exec_phase   = 1'b1;
        pc_load      = w_is_jump && w_cond;
        flags_en     = FLAG_WR_MASK[w_opcode];
        w_state_next = halt_req ? ST_HALT : ST_FETCH;
      end
      default: begin
        w_state_next = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir <= '0;
    end else if (ir_en) begin
      r_ir <= instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (cnt_clr) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (exec_phase && w_is_jump && (r_branch_cnt != {CNT_W{1'b1}})) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (pc_load && (r_taken_cnt != {CNT_W{1'b1}})) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign jump_addr  = r_ir[INSTR_W-5:0];
  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_flag_cond_sequencer.sv
// Directed-vector bench for flag_cond_sequencer; outputs are sampled on the falling edge.
module tb_flag_cond_sequencer;

  logic       clk;
  logic       reset;
  logic       halt_req;
  logic [7:0] instr;
  logic       c_flag;
  logic       z_flag;
  logic       cnt_clr;
  logic       ir_en;
  logic       pc_inc;
  logic       pc_load;
  logic [3:0] jump_addr;
  logic       flags_en;
  logic       exec_phase;
  logic [7:0] branch_cnt;
  logic [7:0] taken_cnt;

  int total;
  int bad;
  int exp_b;
  int exp_t;

  flag_cond_sequencer #(
    .INSTR_W(8),
    .CNT_W(8),
    .FLAG_WR_MASK(16'hF0FC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .halt_req(halt_req),
    .instr(instr),
    .c_flag(c_flag),
    .z_flag(z_flag),
    .cnt_clr(cnt_clr),
    .ir_en(ir_en),
    .pc_inc(pc_inc),
    .pc_load(pc_load),
    .jump_addr(jump_addr),
    .flags_en(flags_en),
    .exec_phase(exec_phase),
    .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge while in FETCH; returns at the falling edge inside EXEC.
  task automatic fetch_exec(input logic [7:0] ins, input logic c, input logic z);
    instr  = ins;
    c_flag = c;
    z_flag = z;
    @(negedge clk);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    halt_req = 1'b0;
    instr    = 8'h00;
    c_flag   = 1'b0;
    z_flag   = 1'b0;
    cnt_clr  = 1'b0;

    // 1: reset and start-up sequence
    repeat (3) @(negedge clk);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_pc_inc", pc_inc, 0);
    chk("rst_exec", exec_phase, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_branch", branch_cnt, 0);
    chk("rst_taken", taken_cnt, 0);
    reset = 1'b1;
    #1;
    chk("halt_ir_en", ir_en, 0);
    @(negedge clk);
    chk("fetch_ir_en", ir_en, 1);
    chk("fetch_pc_inc", pc_inc, 1);
    chk("fetch_exec", exec_phase, 0);

    // 2: JC 5 taken, then not taken
    fetch_exec(8'h05, 1'b1, 1'b0);
    chk("jc_exec", exec_phase, 1);
    chk("jc_pc_load", pc_load, 1);
    chk("jc_pc_inc", pc_inc, 0);
    chk("jc_addr", jump_addr, 4'h5);
    chk("jc_flags_en", flags_en, 0);
    @(negedge clk);
    $display("txn JC5 c=1: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("jc_branch", branch_cnt, 1);
    chk("jc_taken", taken_cnt, 1);
    fetch_exec(8'h05, 1'b0, 1'b0);
    chk("jc_nt_pc_load", pc_load, 0);
    @(negedge clk);
    $display("txn JC5 c=0: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("jc_nt_branch", branch_cnt, 2);
    chk("jc_nt_taken", taken_cnt, 1);

    // 3: JNZ 3 both ways
    fetch_exec(8'h93, 1'b0, 1'b1);
    chk("jnz_z1_pc_load", pc_load, 0);
    @(negedge clk);
    $display("txn JNZ3 z=1: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("jnz_z1_branch", branch_cnt, 3);
    fetch_exec(8'h93, 1'b0, 1'b0);
    chk("jnz_z0_pc_load", pc_load, 1);
    chk("jnz_z0_addr", jump_addr, 4'h3);
    @(negedge clk);
    $display("txn JNZ3 z=0: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("jnz_z0_branch", branch_cnt, 4);
    chk("jnz_z0_taken", taken_cnt, 2);

    // 4: ALU op writes flags, NOP does not, neither counts
    fetch_exec(8'h27, 1'b1, 1'b1);
    chk("alu_flags_en", flags_en, 1);
    chk("alu_pc_load", pc_load, 0);
    @(negedge clk);
    $display("txn ALU27: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("alu_branch", branch_cnt, 4);
    chk("alu_taken", taken_cnt, 2);
    fetch_exec(8'hB0, 1'b1, 1'b1);
    chk("nop_flags_en", flags_en, 0);
    chk("nop_pc_load", pc_load, 0);
    @(negedge clk);
    $display("txn NOP: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("nop_branch", branch_cnt, 4);
    fetch_exec(8'hE1, 1'b0, 1'b0);
    chk("aluE_flags_en", flags_en, 1);
    @(negedge clk);
    fetch_exec(8'h8A, 1'b0, 1'b1);
    chk("jz_pc_load", pc_load, 1);
    chk("jz_addr", jump_addr, 4'hA);
    @(negedge clk);
    $display("txn JZ10 z=1: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("jz_branch", branch_cnt, 5);
    chk("jz_taken", taken_cnt, 3);

    // 5: saturation over 260 JMPs
    exp_b = 5;
    exp_t = 3;
    for (int i = 0; i < 260; i++) begin
      fetch_exec(8'hA7, 1'b0, 1'b0);
      chk("jmp_pc_load", pc_load, 1);
      @(negedge clk);
      if (exp_b < 255) exp_b++;
      if (exp_t < 255) exp_t++;
      chk("sat_branch", branch_cnt, exp_b);
      chk("sat_taken", taken_cnt, exp_t);
    end
    $display("txn 260xJMP: branch=%0h taken=%0h", branch_cnt, taken_cnt);
    chk("sat_branch_ff", branch_cnt, 8'hFF);
    chk("sat_taken_ff", taken_cnt, 8'hFF);
    fetch_exec(8'hA2, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    chk("clr_pc_load", pc_load, 1);
    @(negedge clk);
    cnt_clr = 1'b0;
    $display("txn JMP+clr: branch=%0d taken=%0d", branch_cnt, taken_cnt);
    chk("clr_branch", branch_cnt, 0);
    chk("clr_taken", taken_cnt, 0);

    // 6: async reset mid-EXEC of a taken JC
    fetch_exec(8'hA1, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_taken", taken_cnt, 1);
    fetch_exec(8'h05, 1'b1, 1'b0);
    chk("pre_rst_pc_load", pc_load, 1);
    #2;
    reset = 1'b0;
    #1;
    $display("txn reset mid-EXEC: pc_load=%0d exec=%0d", pc_load, exec_phase);
    chk("rst_mid_pc_load", pc_load, 0);
    chk("rst_mid_exec", exec_phase, 0);
    chk("rst_mid_branch", branch_cnt, 0);
    chk("rst_mid_taken", taken_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_halt", ir_en, 0);
    @(negedge clk);
    chk("rst_fetch_ir_en", ir_en, 1);

    // halt_req during FETCH lets the instruction finish, then HALT
    halt_req = 1'b1;
    fetch_exec(8'hA4, 1'b0, 1'b0);
    chk("halt_exec", exec_phase, 1);
    chk("halt_exec_pc_load", pc_load, 1);
    @(negedge clk);
    $display("txn JMP with halt_req: exec=%0d taken=%0d", exec_phase, taken_cnt);
    chk("halt_state_exec", exec_phase, 0);
    chk("halt_state_ir_en", ir_en, 0);
    chk("halt_taken", taken_cnt, 1);
    @(negedge clk);
    chk("halt_hold_ir_en", ir_en, 0);
    halt_req = 1'b0;
    @(negedge clk);
    chk("resume_ir_en", ir_en, 1);
    chk("resume_pc_inc", pc_inc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
